pwm_driver: RTL and testbench

PWM_DRIVER -- requirements
Module: pwm_driver

---
 rtl/pwm_pkg.sv | 20 ++
 rtl/pwm_deadtime.sv | 73 +++++++
 rtl/pwm_driver.sv | 122 ++++++++++++
 tb/tb_pwm_driver.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM driver: controller states, dead-time output
// sides and the fixed duty/period geometry.
package pwm_pkg;

    localparam int DUTY_W     = 7;
    localparam int PERIOD_MAX = 126;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FAULT = 2'd2
    } pwm_state_e;

    typedef enum logic [1:0] {
        SIDE_OFF = 2'd0,
        SIDE_HI  = 2'd1,
        SIDE_LO  = 2'd2
    } pwm_side_e;

endpackage

// File: rtl/pwm_deadtime.sv
// Dead-time inserter: drives the requested side only after the request has been
// stable for DEADTIME clks, keeping both sides low while a change settles.
module pwm_deadtime
    import pwm_pkg::*;
#(
    parameter int DEADTIME = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic active_i,
    input  logic raw_i,
    output logic hi_o,
    output logic lo_o
);

    localparam logic [3:0] DEAD_CLKS = 4'(DEADTIME);

    pwm_side_e  want;
    pwm_side_e  wantPrev_q, wantPrev_d;
    logic [3:0] deadCnt_q, deadCnt_d;
    logic       hi_q, hi_d;
    logic       lo_q, lo_d;
    logic       assertNow;

    // Any change of requested side restarts the dead window, so a pulse no
    // longer than the window never reaches its output.
    always_comb begin
        want       = SIDE_OFF;
        wantPrev_d = SIDE_OFF;
        deadCnt_d  = deadCnt_q;
        assertNow  = 1'b0;
        hi_d       = 1'b0;
        lo_d       = 1'b0;

        if (active_i) begin
            want = raw_i ? SIDE_HI : SIDE_LO;
        end
        wantPrev_d = want;

        if (want != wantPrev_q) begin
            deadCnt_d = DEAD_CLKS;
            assertNow = (DEAD_CLKS == 4'd0);
        end else if (deadCnt_q > 4'd1) begin
            deadCnt_d = deadCnt_q - 4'd1;
        end else begin
            deadCnt_d = 4'd0;
            assertNow = 1'b1;
        end

        if (assertNow) begin
            hi_d = (want == SIDE_HI);
            lo_d = (want == SIDE_LO);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wantPrev_q <= SIDE_OFF;
            deadCnt_q  <= 4'd0;
            hi_q       <= 1'b0;
            lo_q       <= 1'b0;
        end else begin
            wantPrev_q <= wantPrev_d;
            deadCnt_q  <= deadCnt_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
        end
    end

    assign hi_o = hi_q;
    assign lo_o = lo_q;

endmodule

// File: rtl/pwm_driver.sv
// Single-channel PWM driver with prescaler, shadowed duty and fault shutdown.
// Optional complementary low side with dead-time when PWM_DEADTIME_EN is defined.
module pwm_driver
    import pwm_pkg::*;
#(
    parameter int PRESCALE = 4,
    parameter int DEADTIME = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic [DUTY_W-1:0] duty,
    input  logic              fault,
    output logic              pwm_hi,
    output logic              pwm_lo,
    output logic              period_start,
    output logic [DUTY_W-1:0] duty_applied,
    output logic              fault_latched
);

    localparam logic [7:0]        PRESCALE_LAST = 8'(PRESCALE - 1);
    localparam logic [DUTY_W-1:0] PERIOD_LAST   = DUTY_W'(PERIOD_MAX);

    if (PRESCALE < 1 || PRESCALE > 255 || DEADTIME < 0 || DEADTIME > 15) begin : gBadParams
        $error("pwm_driver: PRESCALE must be 1..255 and DEADTIME 0..15");
    end

    pwm_state_e        state_q, state_d;
    logic [7:0]        preCnt_q, preCnt_d;
    logic [DUTY_W-1:0] periodCnt_q, periodCnt_d;
    logic [DUTY_W-1:0] dutyApplied_q, dutyApplied_d;
    logic              tick;
    logic              wrap;
    logic              raw;
    logic              stayRun;

    assign tick    = (preCnt_q == PRESCALE_LAST);
    assign wrap    = (state_q == RUN) && tick && (periodCnt_q == PERIOD_LAST);
    assign raw     = (periodCnt_q < dutyApplied_q);
    assign stayRun = (state_q == RUN) && (state_d == RUN);

    // Fault overrides every other transition; RUN only leaves on a wrap so the
    // period in flight always completes.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (en) state_d = RUN;
            RUN:     if (wrap && !en) state_d = IDLE;
            FAULT:   if (!en) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (fault) begin
            state_d = FAULT;
        end
    end

    // Counters only run while staying in RUN; anything else parks them at 0.
    always_comb begin
        preCnt_d      = '0;
        periodCnt_d   = '0;
        dutyApplied_d = dutyApplied_q;

        if (stayRun) begin
            if (tick) begin
                periodCnt_d = (periodCnt_q == PERIOD_LAST) ? '0 : periodCnt_q + 1'b1;
            end else begin
                preCnt_d    = preCnt_q + 8'd1;
                periodCnt_d = periodCnt_q;
            end
            if (wrap) begin
                dutyApplied_d = duty;
            end
        end else if (state_q != RUN && state_d == RUN) begin
            dutyApplied_d = duty;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= IDLE;
            preCnt_q      <= '0;
            periodCnt_q   <= '0;
            dutyApplied_q <= '0;
        end else begin
            state_q       <= state_d;
            preCnt_q      <= preCnt_d;
            periodCnt_q   <= periodCnt_d;
            dutyApplied_q <= dutyApplied_d;
        end
    end

    assign period_start  = (state_q == RUN) && tick && (periodCnt_q == '0);
    assign duty_applied  = dutyApplied_q;
    assign fault_latched = (state_q == FAULT);

`ifdef PWM_DEADTIME_EN
    pwm_deadtime #(
        .DEADTIME (DEADTIME)
    ) u_deadtime (
        .clk      (clk),
        .reset    (reset),
        .active_i (stayRun),
        .raw_i    (raw),
        .hi_o     (pwm_hi),
        .lo_o     (pwm_lo)
    );
`else
    logic hi_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hi_q <= 1'b0;
        end else begin
            hi_q <= stayRun && raw;
        end
    end

    assign pwm_hi = hi_q;
    assign pwm_lo = 1'b0;
`endif

endmodule

// File: tb/tb_pwm_driver.sv
// Self-checking bench for pwm_driver: two instances (PRESCALE 1 and 3) share
// stimulus and are compared each clk against a time-since-entry reference model.
module tb_pwm_driver;

    localparam int PA = 1;
    localparam int PB = 3;
    localparam int DT = 2;
`ifdef PWM_DEADTIME_EN
    localparam int HIDT = DT;
`else
    localparam int HIDT = 0;
`endif

    logic       clk   = 1'b0;
    logic       reset = 1'b0;
    logic       en    = 1'b0;
    logic       fault = 1'b0;
    logic [6:0] duty  = 7'd0;

    logic       hiA, loA, psA, flA;
    logic [6:0] daA;
    logic       hiB, loB, psB, flB;
    logic [6:0] daB;

    int nTests = 0;
    int nFail  = 0;

    // st: 0 idle, 1 run, 2 fault; runClk counts clks since entering RUN.
    // want: 0 off, 1 high side, 2 low side; stable counts identical samples.
    typedef struct {
        int st;
        int runClk;
        int duty;
        bit hi;
        int want;
        int stable;
        bit dtHi;
        bit dtLo;
    } model_t;

    model_t mA, mB;

    typedef struct {
        bit e;
        bit f;
        int d;
        int hold;
        bit expHi;
        bit expPs;
        bit expFl;
        int expDa;
    } vec_t;

    always #5 clk = ~clk;

    pwm_driver #(.PRESCALE(PA), .DEADTIME(DT)) dutA (
        .clk(clk), .reset(reset), .en(en), .duty(duty), .fault(fault),
        .pwm_hi(hiA), .pwm_lo(loA), .period_start(psA),
        .duty_applied(daA), .fault_latched(flA)
    );

    pwm_driver #(.PRESCALE(PB), .DEADTIME(DT)) dutB (
        .clk(clk), .reset(reset), .en(en), .duty(duty), .fault(fault),
        .pwm_hi(hiB), .pwm_lo(loB), .period_start(psB),
        .duty_applied(daB), .fault_latched(flB)
    );

    function automatic model_t resetModel();
        model_t m;
        m.st = 0; m.runClk = 0; m.duty = 0; m.hi = 1'b0;
        m.want = 0; m.stable = 1; m.dtHi = 1'b0; m.dtLo = 1'b0;
        return m;
    endfunction

    function automatic model_t stepModel(model_t m, int p, bit e, bit f, int d);
        model_t n     = m;
        int     pos   = (m.runClk / p) % 127;
        bit     isRun = (m.st == 1);
        bit     wrapN = isRun && ((m.runClk % p) == p - 1) && (pos == 126);
        bit     raw   = isRun && (pos < m.duty);
        int     w;
        n.hi = 1'b0;
        if (f) begin
            n.st = 2; n.runClk = 0;
        end else if (m.st == 0) begin
            if (e) begin n.st = 1; n.runClk = 0; n.duty = d; end
        end else if (m.st == 1) begin
            if (wrapN && !e) begin
                n.st = 0; n.runClk = 0;
            end else begin
                n.hi = raw;
                n.runClk = m.runClk + 1;
                if (wrapN) n.duty = d;
            end
        end else begin
            if (!e) n.st = 0;
        end
        w = (isRun && n.st == 1) ? (raw ? 1 : 2) : 0;
        n.stable = (w == m.want) ? m.stable + 1 : 1;
        n.want   = w;
        n.dtHi   = (w == 1) && (n.stable >= DT + 1);
        n.dtLo   = (w == 2) && (n.stable >= DT + 1);
        return n;
    endfunction

    function automatic bit expPs(model_t m, int p);
        return (m.st == 1) && ((m.runClk % p) == p - 1) && (((m.runClk / p) % 127) == 0);
    endfunction

    task automatic checkInt(string name, logic [31:0] act, int exp);
        nTests++;
        if (act !== 32'(exp)) begin
            nFail++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic checkDut(string tag, logic hi, logic lo, logic ps, logic [6:0] da,
                            logic fl, model_t m, int p);
        bit eHi;
        bit eLo;
`ifdef PWM_DEADTIME_EN
        eHi = m.dtHi;
        eLo = m.dtLo;
`else
        eHi = m.hi;
        eLo = 1'b0;
`endif
        checkInt({tag, ".pwm_hi"}, 32'(hi), int'(eHi));
        checkInt({tag, ".pwm_lo"}, 32'(lo), int'(eLo));
        checkInt({tag, ".period_start"}, 32'(ps), int'(expPs(m, p)));
        checkInt({tag, ".duty_applied"}, 32'(da), m.duty);
        checkInt({tag, ".fault_latched"}, 32'(fl), int'(m.st == 2));
    endtask

    task automatic checkOutput();
        checkDut("A", hiA, loA, psA, daA, flA, mA, PA);
        checkDut("B", hiB, loB, psB, daB, flB, mB, PB);
    endtask

    task automatic applyStimulus(bit e, bit f, int d);
        en    = e;
        fault = f;
        duty  = 7'(d);
        @(posedge clk);
        mA = stepModel(mA, PA, e, f, d);
        mB = stepModel(mB, PB, e, f, d);
        #1;
        checkOutput();
    endtask

    task automatic doReset();
        en    = 1'b0;
        fault = 1'b0;
        reset = 1'b0;
        #1;
        mA = resetModel();
        mB = resetModel();
        checkOutput();
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        vec_t vecs[11];
        int   cnt;
        int   psCnt;
        int   daMid;
        int   daWrap;
        bit   curEn;
        int   curDuty;
        bit   f;

        vecs[0]  = '{1'b0, 1'b0, 64,   3, 1'b0, 1'b0, 1'b0, 0};
        vecs[1]  = '{1'b1, 1'b0, 64,   1, 1'b0, 1'b1, 1'b0, 64};
        vecs[2]  = '{1'b1, 1'b0, 64,   1, 1'b1, 1'b0, 1'b0, 64};
        vecs[3]  = '{1'b1, 1'b0, 64,  63, 1'b1, 1'b0, 1'b0, 64};
        vecs[4]  = '{1'b1, 1'b0, 64,   1, 1'b0, 1'b0, 1'b0, 64};
        vecs[5]  = '{1'b1, 1'b1, 64,   1, 1'b0, 1'b0, 1'b1, 64};
        vecs[6]  = '{1'b1, 1'b0, 64,   5, 1'b0, 1'b0, 1'b1, 64};
        vecs[7]  = '{1'b0, 1'b0, 64,   1, 1'b0, 1'b0, 1'b0, 64};
        vecs[8]  = '{1'b1, 1'b0, 127,  2, 1'b1, 1'b0, 1'b0, 127};
        vecs[9]  = '{1'b1, 1'b0, 127, 200, 1'b1, 1'b0, 1'b0, 127};
        vecs[10] = '{1'b0, 1'b0, 127, 60, 1'b0, 1'b0, 1'b0, 127};

        doReset();
        for (int k = 0; k < 11; k++) begin
            for (int h = 0; h < vecs[k].hold; h++) begin
                applyStimulus(vecs[k].e, vecs[k].f, vecs[k].d);
            end
`ifndef PWM_DEADTIME_EN
            checkInt($sformatf("vec%0d.pwm_hi", k), 32'(hiA), int'(vecs[k].expHi));
`endif
            checkInt($sformatf("vec%0d.period_start", k), 32'(psA), int'(vecs[k].expPs));
            checkInt($sformatf("vec%0d.fault_latched", k), 32'(flA), int'(vecs[k].expFl));
            checkInt($sformatf("vec%0d.duty_applied", k), 32'(daA), vecs[k].expDa);
        end

        // Asynchronous reset in the middle of a running period.
        doReset();
        applyStimulus(1'b1, 1'b0, 64);
        for (int i = 0; i < 30; i++) applyStimulus(1'b1, 1'b0, 64);
        #2;
        reset = 1'b0;
        #1;
        checkInt("rst.pwm_hi", 32'(hiA), 0);
        checkInt("rst.period_start", 32'(psB), 0);
        checkInt("rst.duty_applied", 32'(daA), 0);
        doReset();
        for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b0, 99);

        // Mid-period duty change only takes effect at the wrap.
        doReset();
        applyStimulus(1'b1, 1'b0, 32);
        cnt = 0; psCnt = 0; daMid = -1; daWrap = -1;
        for (int i = 1; i <= 127; i++) begin
            applyStimulus(1'b1, 1'b0, (i >= 50) ? 100 : 32);
            cnt += int'(hiA);
            psCnt += int'(psA);
            if (i == 126) daMid = int'(daA);
            if (i == 127) daWrap = int'(daA);
        end
        checkInt("shadow.hi_first", 32'(cnt), 32 - HIDT);
        checkInt("shadow.ps_first", 32'(psCnt), 1);
        checkInt("shadow.da_before_wrap", 32'(daMid), 32);
        checkInt("shadow.da_after_wrap", 32'(daWrap), 100);
        cnt = 0; psCnt = 0;
        for (int i = 128; i <= 254; i++) begin
            applyStimulus(1'b1, 1'b0, 100);
            cnt += int'(hiA);
            psCnt += int'(psA);
        end
        checkInt("shadow.hi_second", 32'(cnt), 100 - HIDT);
        checkInt("shadow.ps_second", 32'(psCnt), 1);

        // Duty 0 never drives the high side.
        doReset();
        applyStimulus(1'b1, 1'b0, 0);
        cnt = 0; psCnt = 0;
        for (int i = 1; i <= 130; i++) begin
            applyStimulus(1'b1, 1'b0, 0);
            cnt += int'(hiA);
            psCnt += int'(psA);
        end
        checkInt("duty0.hi", 32'(cnt), 0);
        checkInt("duty0.ps", 32'(psCnt), 1);

        // Full duty with en dropped at counter 10: runs to the wrap, then idles.
        doReset();
        applyStimulus(1'b1, 1'b0, 127);
        cnt = 0;
        for (int i = 1; i <= 132; i++) begin
            applyStimulus(i <= 10, 1'b0, 127);
            cnt += int'(hiA);
        end
        checkInt("endrop.hi", 32'(cnt), 126 - HIDT);
        checkInt("endrop.idle_hi", 32'(hiA), 0);

        // Fault at counter 5, held in FAULT while en stays high.
        doReset();
        applyStimulus(1'b1, 1'b0, 64);
        for (int i = 1; i <= 5; i++) applyStimulus(1'b1, 1'b0, 64);
        applyStimulus(1'b1, 1'b1, 64);
        checkInt("fault.hi", 32'(hiA), 0);
        checkInt("fault.latched", 32'(flA), 1);
        for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b0, 64);
        checkInt("fault.hold", 32'(flA), 1);
        applyStimulus(1'b0, 1'b0, 64);
        checkInt("fault.exit", 32'(flA), 0);

        // Fault on the wrap clk blocks the shadow duty update.
        doReset();
        applyStimulus(1'b1, 1'b0, 20);
        for (int i = 1; i <= 126; i++) applyStimulus(1'b1, 1'b0, 20);
        applyStimulus(1'b1, 1'b1, 90);
        checkInt("faultwrap.duty_applied", 32'(daA), 20);
        checkInt("faultwrap.latched", 32'(flA), 1);

`ifdef PWM_DEADTIME_EN
        begin
            int  fallIdx;
            int  riseIdx;
            bit  prevLo;
            bit  prevHi;
            doReset();
            applyStimulus(1'b1, 1'b0, 10);
            fallIdx = -1; riseIdx = -1; prevLo = 1'b0; prevHi = 1'b0;
            for (int i = 1; i <= 200; i++) begin
                applyStimulus(1'b1, 1'b0, 10);
                if (i > 20 && prevLo && !loA && fallIdx < 0) fallIdx = i;
                if (fallIdx >= 0 && !prevHi && hiA && riseIdx < 0) riseIdx = i;
                prevLo = loA;
                prevHi = hiA;
            end
            checkInt("dt.edges_seen", 32'(int'(fallIdx >= 0 && riseIdx >= 0)), 1);
            checkInt("dt.gap", 32'(riseIdx - fallIdx), DT);
            doReset();
            applyStimulus(1'b1, 1'b0, 1);
            cnt = 0;
            for (int i = 1; i <= 260; i++) begin
                applyStimulus(1'b1, 1'b0, 1);
                cnt += int'(hiA);
            end
            checkInt("dt.short_pulse", 32'(cnt), 0);
        end
`endif

        // Randomized run against the reference model.
        doReset();
        curEn   = 1'b1;
        curDuty = int'($urandom_range(0, 127));
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 299) == 0) curEn = !curEn;
            if (!curEn && $urandom_range(0, 49) == 0) curEn = 1'b1;
            if ($urandom_range(0, 39) == 0) curDuty = int'($urandom_range(0, 127));
            f = ($urandom_range(0, 249) == 0);
            applyStimulus(curEn, f, curDuty);
        end

        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule
